// File: rtl/jesd204b_adc_framer_emul_pkg.sv
// Shared JESD204B framer definitions: control characters, state encoding and
// the ILAS link-configuration octet builder (L=1, F=4, M=2, N=NP=16, S=1).
package jesd204b_adc_framer_emul_pkg;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;

  localparam logic [2:0] JESDV     = 3'd1;
  localparam logic [2:0] SUBCLASSV = 3'd1;
  localparam logic [4:0] L_M1      = 5'd0;
  localparam logic [7:0] F_M1      = 8'd3;
  localparam logic [7:0] M_M1      = 8'd1;
  localparam logic [4:0] N_M1      = 5'd15;
  localparam logic [4:0] NP_M1     = 5'd15;
  localparam logic [4:0] S_M1      = 5'd0;

  localparam logic [14:0] SCR_SEED = 15'h7FFF;

  function automatic logic [7:0] cfg_field(input logic [3:0] idx, input logic [7:0] did,
                                           input logic [3:0] bid, input logic [4:0] lid,
                                           input logic scr, input logic [4:0] k_m1);
    logic [7:0] res;
    case (idx)
      4'd0:    res = did;
      4'd1:    res = {4'h0, bid};
      4'd2:    res = {3'b000, lid};
      4'd3:    res = {scr, 2'b00, L_M1};
      4'd4:    res = F_M1;
      4'd5:    res = {3'b000, k_m1};
      4'd6:    res = M_M1;
      4'd7:    res = {3'b000, N_M1};
      4'd8:    res = {SUBCLASSV, NP_M1};
      4'd9:    res = {JESDV, S_M1};
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] cfg_octet(input logic [3:0] idx, input logic [7:0] did,
                                           input logic [3:0] bid, input logic [4:0] lid,
                                           input logic scr, input logic [4:0] k_m1);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 13; i++) sum = sum + cfg_field(4'(i), did, bid, lid, scr, k_m1);
    return (idx == 4'd13) ? sum : cfg_field(idx, did, bid, lid, scr, k_m1);
  endfunction

  // Returns {k_flag, octet} for one ILAS octet; position = frame*4 + byte lane.
  function automatic logic [8:0] ilas_octet(input logic [1:0] mf, input logic [4:0] frame,
                                            input logic [1:0] lane_byte, input logic [4:0] k_m1,
                                            input logic [7:0] did, input logic [3:0] bid,
                                            input logic [4:0] lid, input logic scr);
    logic [7:0] pos;
    logic [8:0] res;
    pos = {1'b0, frame, lane_byte};
    res = {1'b0, pos};
    if (frame == 5'd0 && lane_byte == 2'd0)            res = {1'b1, K28_0};
    else if (frame == k_m1 && lane_byte == 2'd3)       res = {1'b1, K28_3};
    else if (mf == 2'd1 && pos == 8'd1)                res = {1'b1, K28_4};
    else if (mf == 2'd1 && pos >= 8'd2 && pos <= 8'd15)
      res = {1'b0, cfg_octet(4'(pos - 8'd2), did, bid, lid, scr, k_m1)};
    return res;
  endfunction

endpackage

// File: rtl/jesd204b_adc_framer_emul_scrambler.sv
// 32-bit parallel self-synchronous scrambler, 1 + x^14 + x^15. Octet 0 goes
// first on the line, MSB first within each octet.
module jesd204b_scrambler_32
  import jesd204b_adc_framer_emul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [14:0] state_q, state_d;
  logic [14:0] hist;
  logic        bit_s;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    hist  = state_q;
    bit_s = 1'b0;
    dout  = din;
    for (int t = 0; t < 32; t++) begin
      bit_s = din[t ^ 7] ^ hist[13] ^ hist[14];
      if (en) dout[t ^ 7] = bit_s;
      hist = {hist[13:0], bit_s};
    end
    if (init)    state_d = SCR_SEED;
    else if (en) state_d = hist;
    else         state_d = state_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_b) state_q <= SCR_SEED;
    else          state_q <= state_d;
  end

endmodule

// File: rtl/jesd204b_adc_framer_emul.sv
// Single-lane JESD204B subclass-1 converter-side framer: LMFC, CGS/ILAS/DATA
// sequencing, sync_b filtering and a registered 32-bit GT word (F=4, one frame per clock).
module jesd204b_adc_framer_emul
  import jesd204b_adc_framer_emul_pkg::*;
#(
  parameter int unsigned K          = 32,
  parameter logic [7:0]  DID        = 8'h00,
  parameter logic [3:0]  BID        = 4'h0,
  parameter int unsigned SYNC_LOW_N = 8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        sysref,
  input  logic        sync_b,
  input  logic        scrambler_is_on,
  input  logic [4:0]  lane_id,
  input  logic [15:0] tx_data_i,
  input  logic [15:0] tx_data_q,
  output logic [31:0] tx_par_data,
  output logic [3:0]  tx_datak,
  output logic        lmfc,
  output logic [1:0]  state_out,
  output logic [15:0] err_report_cnt
);

  localparam int             LOW_W = $clog2(SYNC_LOW_N + 1);
  localparam logic [4:0]     K_M1  = 5'(K - 1);
  localparam logic [LOW_W-1:0] LOW_N = LOW_W'(SYNC_LOW_N);

  state_e            state_q, state_d;
  logic [4:0]        lmfc_cnt_q, lmfc_cnt_d;
  logic              sysref_q;
  logic              lmfc_q;
  logic [1:0]        ilas_mf_q, ilas_mf_d;
  logic [4:0]        ilas_frame_q, ilas_frame_d;
  logic              scr_on_q, scr_on_d;
  logic [LOW_W-1:0]  low_run_q, low_run_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       par_data_q, par_data_d;
  logic [3:0]        datak_q, datak_d;
  logic              resync, short_pulse;
  logic              scr_init, scr_en;
  logic [31:0]       scr_din, scr_dout;
  logic [31:0]       ilas_word;
  logic [3:0]        ilas_k;

  always_comb begin
    if (sysref && !sysref_q)      lmfc_cnt_d = '0;
    else if (lmfc_cnt_q == K_M1)  lmfc_cnt_d = '0;
    else                          lmfc_cnt_d = lmfc_cnt_q + 5'd1;
  end

  // Run length of consecutive sync_b-low clocks, saturating at SYNC_LOW_N.
  always_comb begin
    if (sync_b)                 low_run_d = '0;
    else if (low_run_q == LOW_N) low_run_d = low_run_q;
    else                        low_run_d = low_run_q + LOW_W'(1);
    resync      = (low_run_d == LOW_N) && (state_q != ST_CGS);
    short_pulse = sync_b && (low_run_q != '0) && (low_run_q < LOW_N) && (state_q == ST_DATA);
    err_cnt_d   = (short_pulse && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    ilas_mf_d    = ilas_mf_q;
    ilas_frame_d = ilas_frame_q;
    scr_on_d     = scr_on_q;
    unique case (state_q)
      ST_CGS: begin
        if (sync_b && lmfc_cnt_q == K_M1) begin
          state_d      = ST_ILAS;
          scr_on_d     = scrambler_is_on;
          ilas_mf_d    = '0;
          ilas_frame_d = '0;
        end
      end
      ST_ILAS: begin
        if (resync) begin
          state_d = ST_CGS;
        end else if (ilas_frame_q == K_M1) begin
          ilas_frame_d = '0;
          if (ilas_mf_q == 2'd3) state_d = ST_DATA;
          else                   ilas_mf_d = ilas_mf_q + 2'd1;
        end else begin
          ilas_frame_d = ilas_frame_q + 5'd1;
        end
      end
      ST_DATA: begin
        if (resync) state_d = ST_CGS;
      end
      default: state_d = ST_CGS;
    endcase
  end

  // The output register is loaded with the word belonging to the next state.
  always_comb begin
    ilas_word = '0;
    ilas_k    = '0;
    for (int j = 0; j < 4; j++) begin
      {ilas_k[j], ilas_word[8*j +: 8]} = ilas_octet(ilas_mf_d, ilas_frame_d, 2'(j), K_M1,
                                                    DID, BID, lane_id, scr_on_q);
    end
  end

  assign scr_init = (state_q == ST_CGS) && (state_d == ST_ILAS);
  assign scr_en   = (state_d == ST_DATA) && scr_on_q;
  assign scr_din  = {tx_data_q[7:0], tx_data_q[15:8], tx_data_i[7:0], tx_data_i[15:8]};

  jesd204b_scrambler_32 u_scrambler (
    .clk     (clk),
    .reset_b (reset_b),
    .init    (scr_init),
    .en      (scr_en),
    .din     (scr_din),
    .dout    (scr_dout)
  );

  always_comb begin
    par_data_d = {4{K28_5}};
    datak_d    = 4'hF;
    unique case (state_d)
      ST_ILAS: begin
        par_data_d = ilas_word;
        datak_d    = ilas_k;
      end
      ST_DATA: begin
        par_data_d = scr_dout;
        datak_d    = 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every register, so a mid-run reset_b
    // restores the complete idle image on the following edge.
    if (!reset_b) begin
      state_q      <= ST_CGS;
      lmfc_cnt_q   <= '0;
      sysref_q     <= 1'b0;
      lmfc_q       <= 1'b0;
      ilas_mf_q    <= '0;
      ilas_frame_q <= '0;
      scr_on_q     <= 1'b0;
      low_run_q    <= '0;
      err_cnt_q    <= '0;
      par_data_q   <= {4{K28_5}};
      datak_q      <= 4'hF;
    end else begin
      state_q      <= state_d;
      lmfc_cnt_q   <= lmfc_cnt_d;
      sysref_q     <= sysref;
      lmfc_q       <= (lmfc_cnt_d == 5'd0);
      ilas_mf_q    <= ilas_mf_d;
      ilas_frame_q <= ilas_frame_d;
      scr_on_q     <= scr_on_d;
      low_run_q    <= low_run_d;
      err_cnt_q    <= err_cnt_d;
      par_data_q   <= par_data_d;
      datak_q      <= datak_d;
    end
  end

  assign tx_par_data    = par_data_q;
  assign tx_datak       = datak_q;
  assign lmfc           = lmfc_q;
  assign state_out      = state_q;
  assign err_report_cnt = err_cnt_q;

endmodule
